// File: rtl/snn_core_if.sv
// rtl/snn_core_if.sv - write port and spike I/O bundle for snn_core
//
// Purpose: groups the weight/config write port and the spike/debug streams
// of snn_core so a driver and the core connect through one port.
// Signals:
//   mem_write  weight write strobe
//   cfg_write  config register write strobe
//   wr_addr    weight or config address (32 bits)
//   wr_data    write data, low PRECISION bits used as a signed value
//   spk_in     input spikes for the current timestep
//   spk_out    registered output-layer spikes
//   gpout      monitored neuron vmem, zero-extended
// Modports: master drives writes and spk_in; slave is the core.
interface snn_core_if #(
  parameter int INPUT_NEURONS  = 4,
  parameter int OUTPUT_NEURONS = 2,
  parameter int GPOUT_WIDTH    = 16
);
  logic                      mem_write;
  logic                      cfg_write;
  logic [31:0]               wr_addr;
  logic [31:0]               wr_data;
  logic [INPUT_NEURONS-1:0]  spk_in;
  logic [OUTPUT_NEURONS-1:0] spk_out;
  logic [GPOUT_WIDTH-1:0]    gpout;

  modport master (
    output mem_write, cfg_write, wr_addr, wr_data, spk_in,
    input  spk_out, gpout
  );

  modport slave (
    input  mem_write, cfg_write, wr_addr, wr_data, spk_in,
    output spk_out, gpout
  );
endinterface

// File: rtl/snn_core.sv
// rtl/snn_core.sv - two-layer fully connected LIF spiking network core
//
// Purpose: input spikes -> hidden LIF layer -> output LIF layer, one
// timestep per spkclk edge, with on-chip weight memory and global neuron
// configuration registers written through the bus write port.
// Ports:
//   spkclk  single clock for writes and timesteps
//   rst     synchronous active-high reset (clears weights, state, config)
//   bus     snn_core_if slave: mem_write/cfg_write/wr_addr/wr_data write
//           port, spk_in input spikes, spk_out output spikes, gpout debug
//           vmem of the neuron selected by LAYER/NEURON_TO_MONITOR
module snn_core #(
  parameter int INPUT_NEURONS  = 4,
  parameter int HIDDEN_NEURONS = 4,
  parameter int OUTPUT_NEURONS = 2,
  parameter int PRECISION      = 16,
  parameter int GPOUT_WIDTH    = 16
) (
  input  logic       spkclk,
  input  logic       rst,
  snn_core_if.slave  bus
);

  localparam int MAXN = (INPUT_NEURONS > HIDDEN_NEURONS) ? INPUT_NEURONS : HIDDEN_NEURONS;
  // Wide enough for a full fan-in sum plus the leak step without wrapping.
  localparam int AW = PRECISION + $clog2(MAXN + 1) + 2;
  localparam int L0_BASE = 0;
  localparam int L1_BASE = HIDDEN_NEURONS * INPUT_NEURONS;

  localparam logic signed [AW-1:0] MAXW = {{(AW-PRECISION+1){1'b0}}, {(PRECISION-1){1'b1}}};
  localparam logic signed [AW-1:0] MINW = {{(AW-PRECISION+1){1'b1}}, {(PRECISION-1){1'b0}}};

  typedef struct packed {
    logic signed [PRECISION-1:0] v;
    logic        [PRECISION-1:0] r;
    logic                        s;
  } nstate_t;

  logic signed [PRECISION-1:0] w0 [HIDDEN_NEURONS][INPUT_NEURONS];
  logic signed [PRECISION-1:0] w1 [OUTPUT_NEURONS][HIDDEN_NEURONS];
  // 0 VTH, 1 DECAY, 2 GROW, 3 VREST, 4 RESET_MECH, 5 REFR, 6 LAYER, 7 NEURON
  logic signed [PRECISION-1:0] cfg [8];

  logic signed [PRECISION-1:0] vmem0 [HIDDEN_NEURONS];
  logic        [PRECISION-1:0] refr0 [HIDDEN_NEURONS];
  logic        [HIDDEN_NEURONS-1:0] spk0;
  logic signed [PRECISION-1:0] vmem1 [OUTPUT_NEURONS];
  logic        [PRECISION-1:0] refr1 [OUTPUT_NEURONS];
  logic        [OUTPUT_NEURONS-1:0] spk1;

  nstate_t nxt0 [HIDDEN_NEURONS];
  nstate_t nxt1 [OUTPUT_NEURONS];

  function automatic logic signed [AW-1:0] sx(input logic signed [PRECISION-1:0] x);
    return {{(AW-PRECISION){x[PRECISION-1]}}, x};
  endfunction

  function automatic logic signed [PRECISION-1:0] sat(input logic signed [AW-1:0] x);
    if (x > MAXW)      return MAXW[PRECISION-1:0];
    else if (x < MINW) return MINW[PRECISION-1:0];
    else               return x[PRECISION-1:0];
  endfunction

  // One LIF step: refractory hold, leak toward VREST, integrate, fire.
  function automatic nstate_t upd(input logic signed [PRECISION-1:0] v,
                                  input logic        [PRECISION-1:0] r,
                                  input logic signed [AW-1:0]        isum);
    logic signed [AW-1:0] vw, rest, vl, vs, vth;
    nstate_t n;
    vw   = sx(v);
    rest = sx(cfg[3]);
    vth  = sx(cfg[0]);
    if (vw > rest) begin
      vl = vw - sx(cfg[1]);
      if (vl < rest) vl = rest;
    end else if (vw < rest) begin
      vl = vw + sx(cfg[2]);
      if (vl > rest) vl = rest;
    end else begin
      vl = vw;
    end
    vs = sx(sat(vl + isum));
    if (r != '0) begin
      n.v = cfg[3];
      n.r = r - 1'b1;
      n.s = 1'b0;
    end else if (vs >= vth) begin
      n.v = (cfg[4] == PRECISION'(1)) ? sat(vs - vth) : cfg[3];
      n.r = cfg[5];
      n.s = 1'b1;
    end else begin
      n.v = vs[PRECISION-1:0];
      n.r = '0;
      n.s = 1'b0;
    end
    return n;
  endfunction

  always_comb begin : l0_comb
    logic signed [AW-1:0] acc;
    for (int h = 0; h < HIDDEN_NEURONS; h++) begin
      acc = '0;
      for (int i = 0; i < INPUT_NEURONS; i++)
        if (bus.spk_in[i]) acc = acc + sx(w0[h][i]);
      nxt0[h] = upd(vmem0[h], refr0[h], acc);
    end
  end

  // Output layer sees the hidden spikes registered on the previous edge.
  always_comb begin : l1_comb
    logic signed [AW-1:0] acc;
    for (int o = 0; o < OUTPUT_NEURONS; o++) begin
      acc = '0;
      for (int h = 0; h < HIDDEN_NEURONS; h++)
        if (spk0[h]) acc = acc + sx(w1[o][h]);
      nxt1[o] = upd(vmem1[o], refr1[o], acc);
    end
  end

  always_ff @(posedge spkclk) begin
    if (rst) begin
      for (int h = 0; h < HIDDEN_NEURONS; h++) begin
        for (int i = 0; i < INPUT_NEURONS; i++) w0[h][i] <= '0;
        vmem0[h] <= '0;
        refr0[h] <= '0;
      end
      for (int o = 0; o < OUTPUT_NEURONS; o++) begin
        for (int h = 0; h < HIDDEN_NEURONS; h++) w1[o][h] <= '0;
        vmem1[o] <= '0;
        refr1[o] <= '0;
      end
      spk0 <= '0;
      spk1 <= '0;
      for (int k = 1; k < 8; k++) cfg[k] <= '0;
      cfg[0] <= PRECISION'(100);
    end else begin
      for (int h = 0; h < HIDDEN_NEURONS; h++) begin
        vmem0[h] <= nxt0[h].v;
        refr0[h] <= nxt0[h].r;
        spk0[h]  <= nxt0[h].s;
      end
      for (int o = 0; o < OUTPUT_NEURONS; o++) begin
        vmem1[o] <= nxt1[o].v;
        refr1[o] <= nxt1[o].r;
        spk1[o]  <= nxt1[o].s;
      end
      // Address decode by exact match so out-of-range addresses fall through.
      if (bus.mem_write) begin
        for (int h = 0; h < HIDDEN_NEURONS; h++)
          for (int i = 0; i < INPUT_NEURONS; i++)
            if (bus.wr_addr == 32'(L0_BASE + h*INPUT_NEURONS + i))
              w0[h][i] <= bus.wr_data[PRECISION-1:0];
        for (int o = 0; o < OUTPUT_NEURONS; o++)
          for (int h = 0; h < HIDDEN_NEURONS; h++)
            if (bus.wr_addr == 32'(L1_BASE + o*HIDDEN_NEURONS + h))
              w1[o][h] <= bus.wr_data[PRECISION-1:0];
      end
      if (bus.cfg_write) begin
        for (int k = 0; k < 8; k++)
          if (bus.wr_addr == 32'(k)) cfg[k] <= bus.wr_data[PRECISION-1:0];
      end
    end
  end

  logic [PRECISION-1:0] lsel, nsel, gp;
  assign lsel = cfg[6];
  assign nsel = cfg[7];

  always_comb begin
    gp = '0;
    if (lsel == '0) begin
      for (int h = 0; h < HIDDEN_NEURONS; h++)
        if (nsel == PRECISION'(h)) gp = vmem0[h];
    end else if (lsel == PRECISION'(1)) begin
      for (int o = 0; o < OUTPUT_NEURONS; o++)
        if (nsel == PRECISION'(o)) gp = vmem1[o];
    end
  end

  assign bus.spk_out = spk1;
  assign bus.gpout   = GPOUT_WIDTH'(gp);

  generate
    if (PRECISION < 32) begin : g_unused
      logic unused_wr_data;
      assign unused_wr_data = ^bus.wr_data[31:PRECISION];
    end
  endgenerate

endmodule

// File: tb/tb_snn_core.sv
// tb/tb_snn_core.sv - self-checking bench for snn_core against a behavioural model
module tb_snn_core;
  localparam int NI = 4;
  localparam int NH = 4;
  localparam int NO = 2;
  localparam int P  = 16;
  localparam int GW = 16;

  logic spkclk = 1'b0;
  logic rst    = 1'b1;
  always #5 spkclk = ~spkclk;

  snn_core_if #(.INPUT_NEURONS(NI), .OUTPUT_NEURONS(NO), .GPOUT_WIDTH(GW)) bus ();

  snn_core #(
    .INPUT_NEURONS(NI), .HIDDEN_NEURONS(NH), .OUTPUT_NEURONS(NO),
    .PRECISION(P), .GPOUT_WIDTH(GW)
  ) dut (
    .spkclk(spkclk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int mw0 [NH][NI];
  int mw1 [NO][NH];
  int mcfg [8];
  int mv0 [NH];
  int mr0 [NH];
  bit ms0 [NH];
  int mv1 [NO];
  int mr1 [NO];
  bit ms1 [NO];

  function automatic int sat(input int x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  task automatic neuron(inout int v, inout int r, output bit s, input int isum);
    int vl, vs;
    if (r > 0) begin
      v = mcfg[3];
      r = r - 1;
      s = 0;
    end else begin
      if (v > mcfg[3])      vl = (v - mcfg[1] > mcfg[3]) ? v - mcfg[1] : mcfg[3];
      else if (v < mcfg[3]) vl = (v + mcfg[2] < mcfg[3]) ? v + mcfg[2] : mcfg[3];
      else                  vl = v;
      vs = sat(vl + isum);
      if (vs >= mcfg[0]) begin
        s = 1;
        r = mcfg[5] & 32'hFFFF;
        v = (mcfg[4] == 1) ? sat(vs - mcfg[0]) : mcfg[3];
      end else begin
        s = 0;
        v = vs;
      end
    end
  endtask

  task automatic model_step();
    bit old0 [NH];
    int acc, d;
    longint unsigned a;
    if (rst) begin
      for (int h = 0; h < NH; h++) begin
        mv0[h] = 0; mr0[h] = 0; ms0[h] = 0;
        for (int i = 0; i < NI; i++) mw0[h][i] = 0;
      end
      for (int o = 0; o < NO; o++) begin
        mv1[o] = 0; mr1[o] = 0; ms1[o] = 0;
        for (int h = 0; h < NH; h++) mw1[o][h] = 0;
      end
      for (int k = 0; k < 8; k++) mcfg[k] = 0;
      mcfg[0] = 100;
    end else begin
      old0 = ms0;
      for (int h = 0; h < NH; h++) begin
        acc = 0;
        for (int i = 0; i < NI; i++) if (bus.spk_in[i]) acc += mw0[h][i];
        neuron(mv0[h], mr0[h], ms0[h], acc);
      end
      for (int o = 0; o < NO; o++) begin
        acc = 0;
        for (int h = 0; h < NH; h++) if (old0[h]) acc += mw1[o][h];
        neuron(mv1[o], mr1[o], ms1[o], acc);
      end
      d = int'($signed(bus.wr_data[15:0]));
      a = longint'(bus.wr_addr);
      if (bus.mem_write) begin
        if (a < NH*NI) mw0[a / NI][a % NI] = d;
        else if (a < NH*NI + NO*NH) mw1[(a - NH*NI) / NH][(a - NH*NI) % NH] = d;
      end
      if (bus.cfg_write && a < 8) mcfg[a] = d;
    end
  endtask

  function automatic logic [GW-1:0] exp_gpout();
    int l, n;
    l = mcfg[6] & 32'hFFFF;
    n = mcfg[7] & 32'hFFFF;
    if (l == 0 && n < NH) return GW'(mv0[n] & 32'hFFFF);
    if (l == 1 && n < NO) return GW'(mv1[n] & 32'hFFFF);
    return '0;
  endfunction

  function automatic logic [NO-1:0] exp_spk();
    logic [NO-1:0] s;
    for (int o = 0; o < NO; o++) s[o] = ms1[o];
    return s;
  endfunction

  always @(posedge spkclk) begin
    model_step();
    #1;
    chk("model_spk_out", 32'(bus.spk_out), 32'(exp_spk()));
    chk("model_gpout", 32'(bus.gpout), 32'(exp_gpout()));
  end

  // ---------------- stimulus helpers ----------------
  task automatic wmem(input int a, input int d);
    bus.mem_write = 1'b1; bus.wr_addr = 32'(a); bus.wr_data = 32'(d);
    @(negedge spkclk);
    bus.mem_write = 1'b0;
  endtask

  task automatic wcfg(input int a, input int d);
    bus.cfg_write = 1'b1; bus.wr_addr = 32'(a); bus.wr_data = 32'(d);
    @(negedge spkclk);
    bus.cfg_write = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      bus.mem_write = 1'($urandom);
      bus.cfg_write = 1'($urandom);
      bus.wr_addr   = 32'($urandom_range(0, 9));
      bus.wr_data   = $urandom;
      bus.spk_in    = NI'($urandom);
      @(negedge spkclk);
    end
    rst = 1'b0;
    bus.mem_write = 1'b0; bus.cfg_write = 1'b0; bus.spk_in = '0;
    chk("reset_spk_out", 32'(bus.spk_out), 32'h0);
    chk("reset_gpout", 32'(bus.gpout), 32'h0);
  endtask

  task automatic pulse(input logic [NI-1:0] s);
    bus.spk_in = s;
    @(negedge spkclk);
    bus.spk_in = '0;
  endtask

  initial begin
    bus.mem_write = 1'b0; bus.cfg_write = 1'b0;
    bus.wr_addr = '0; bus.wr_data = '0; bus.spk_in = '0;
    @(negedge spkclk);
    do_reset();

    // Writes during reset must not stick: weights 0 -> spikes do nothing.
    pulse(4'b1111);
    chk("reset_nowrite_gpout", 32'(bus.gpout), 32'h0);
    @(negedge spkclk);
    chk("reset_nowrite_spk", 32'(bus.spk_out), 32'h0);

    // Propagation input0 -> hidden0 -> output0.
    do_reset();
    wmem(0, 150);
    wmem(16, 150);
    pulse(4'b0001);
    chk("prop_k_gpout", 32'(bus.gpout), 32'h0);
    chk("prop_k_spk", 32'(bus.spk_out), 32'h0);
    @(negedge spkclk);
    chk("prop_k1_spk", 32'(bus.spk_out), 32'h1);
    @(negedge spkclk);
    chk("prop_k2_spk", 32'(bus.spk_out), 32'h0);

    // Subtractive reset.
    do_reset();
    wcfg(4, 1);
    wmem(0, 150);
    pulse(4'b0001);
    chk("subreset_gpout", 32'(bus.gpout), 32'd50);
    @(negedge spkclk);
    chk("subreset_hold", 32'(bus.gpout), 32'd50);

    // Leak toward VREST.
    do_reset();
    wcfg(1, 10);
    wmem(0, 60);
    pulse(4'b0001);
    for (int k = 0; k < 8; k++) begin
      chk("leak_gpout", 32'(bus.gpout), 32'((60 - 10*k > 0) ? 60 - 10*k : 0));
      @(negedge spkclk);
    end

    // Grow toward VREST.
    do_reset();
    wcfg(2, 10);
    wmem(0, -30);
    pulse(4'b0001);
    chk("grow_0", 32'(bus.gpout), 32'h0000FFE2);
    @(negedge spkclk);
    chk("grow_1", 32'(bus.gpout), 32'h0000FFEC);
    @(negedge spkclk);
    chk("grow_2", 32'(bus.gpout), 32'h0000FFF6);
    @(negedge spkclk);
    chk("grow_3", 32'(bus.gpout), 32'h0);

    // Refractory period 2 with input held: spikes every third edge.
    do_reset();
    wcfg(5, 2);
    wmem(0, 150);
    wmem(16, 150);
    bus.spk_in = 4'b0001;
    for (int n = 1; n <= 9; n++) begin
      @(negedge spkclk);
      chk("refr_spk", 32'(bus.spk_out), 32'((n % 3) == 2));
      chk("refr_gpout", 32'(bus.gpout), 32'h0);
    end
    bus.spk_in = '0;

    // Positive saturation: VTH at max, second spike saturates and fires.
    do_reset();
    wcfg(0, 32'h7FFF);
    wmem(0, 20000);
    wmem(16, 32767);
    bus.spk_in = 4'b0001;
    @(negedge spkclk);
    chk("satp_first", 32'(bus.gpout), 32'd20000);
    @(negedge spkclk);
    bus.spk_in = '0;
    chk("satp_fire_vmem", 32'(bus.gpout), 32'h0);
    @(negedge spkclk);
    chk("satp_out_spk", 32'(bus.spk_out), 32'h1);

    // Negative saturation and out-of-range monitor selection.
    do_reset();
    wcfg(0, 32'h7FFF);
    wmem(0, -20000);
    bus.spk_in = 4'b0001;
    @(negedge spkclk);
    chk("satn_first", 32'(bus.gpout), 32'h0000B1E0);
    @(negedge spkclk);
    bus.spk_in = '0;
    chk("satn_clip", 32'(bus.gpout), 32'h00008000);
    wcfg(7, 9);
    chk("monitor_oor", 32'(bus.gpout), 32'h0);
    wcfg(7, 0);
    wcfg(6, 2);
    chk("monitor_layer_oor", 32'(bus.gpout), 32'h0);

    // Randomised traffic checked by the per-cycle model compare.
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      bus.spk_in = NI'($urandom);
      bus.cfg_write = ($urandom_range(0, 5) == 0);
      bus.mem_write = ($urandom_range(0, 2) == 0);
      if (bus.cfg_write) begin
        bus.wr_addr = 32'($urandom_range(0, 9));
        case (bus.wr_addr)
          0: bus.wr_data = 32'($urandom_range(50, 400));
          1, 2: bus.wr_data = 32'($urandom_range(0, 30));
          3: bus.wr_data = 32'(int'($urandom_range(0, 40)) - 20);
          4: bus.wr_data = 32'($urandom_range(0, 1));
          5: bus.wr_data = 32'($urandom_range(0, 3));
          6: bus.wr_data = 32'($urandom_range(0, 2));
          7: bus.wr_data = 32'($urandom_range(0, 4));
          default: bus.wr_data = $urandom;
        endcase
      end else begin
        bus.wr_addr = 32'($urandom_range(0, 27));
        if ($urandom_range(0, 15) == 0) bus.wr_data = $urandom;
        else bus.wr_data = 32'(int'($urandom_range(0, 700)) - 300);
      end
      @(negedge spkclk);
    end
    rst = 1'b0;
    bus.mem_write = 1'b0; bus.cfg_write = 1'b0; bus.spk_in = '0;
    @(negedge spkclk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
